// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter read port: register map,
// status word bit positions and the read FSM state type.
package perf_pkg;

    localparam logic [1:0] ADDR_CYCLE   = 2'd0;
    localparam logic [1:0] ADDR_INSTRET = 2'd1;
    localparam logic [1:0] ADDR_STALL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int STAT_HALTED      = 0;
    localparam int STAT_INSTRET_OVF = 1;
    localparam int STAT_STALL_OVF   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/perf_accum.sv
// Enable-gated wrapping counter with a sticky overflow flag that records
// the first wrap since reset.
module perf_accum #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // A wrap happens exactly when an enabled increment starts from all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (en) begin
            count <= count + ONE;
            if (&count) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_reader.sv
// Retirement/stall performance counters with a sticky halt latch, read out
// through a single-outstanding valid/ready request/response port.
module perf_reader
    import perf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             W_v,
    input  logic             isHalt,
    input  logic [WIDTH-1:0] cycle,
    input  logic             rd_req_v,
    output logic             rd_req_rdy,
    input  logic [1:0]       rd_addr,
    output logic             rd_resp_v,
    input  logic             rd_resp_rdy,
    output logic [WIDTH-1:0] rd_resp_data,
    output logic             halted
);

    logic [WIDTH-1:0] instret;
    logic [WIDTH-1:0] stall;
    logic [WIDTH-1:0] halt_cycle;
    logic [WIDTH-1:0] status_word;
    logic [WIDTH-1:0] sel_data;
    logic             instret_ovf;
    logic             stall_ovf;
    rd_state_t        state;

    perf_accum #(.WIDTH(WIDTH)) u_instret (
        .clk      (clk),
        .reset    (reset),
        .en       (W_v && !halted),
        .count    (instret),
        .overflow (instret_ovf)
    );

    perf_accum #(.WIDTH(WIDTH)) u_stall (
        .clk      (clk),
        .reset    (reset),
        .en       (!W_v && !halted),
        .count    (stall),
        .overflow (stall_ovf)
    );

    // The halting edge still counts its own retirement because the counter
    // enables see halted=0 on that edge; everything freezes afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted     <= 1'b0;
            halt_cycle <= '0;
        end else if (!halted && isHalt) begin
            halted     <= 1'b1;
            halt_cycle <= cycle;
        end
    end

    always_comb begin
        status_word                   = '0;
        status_word[STAT_HALTED]      = halted;
        status_word[STAT_INSTRET_OVF] = instret_ovf;
        status_word[STAT_STALL_OVF]   = stall_ovf;
    end

    always_comb begin
        sel_data = '0;
        case (rd_addr)
            ADDR_CYCLE:   sel_data = halted ? halt_cycle : cycle;
            ADDR_INSTRET: sel_data = instret;
            ADDR_STALL:   sel_data = stall;
            ADDR_STATUS:  sel_data = status_word;
            default:      sel_data = '0;
        endcase
    end

    assign rd_req_rdy = (state == IDLE);

    // Response data is captured once at acceptance so it stays frozen while
    // the consumer back-pressures, even though the counters keep moving.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rd_resp_v    <= 1'b0;
            rd_resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req_v) begin
                        state        <= RESP;
                        rd_resp_v    <= 1'b1;
                        rd_resp_data <= sel_data;
                    end
                end
                RESP: begin
                    if (rd_resp_rdy) begin
                        state        <= IDLE;
                        rd_resp_v    <= 1'b0;
                        rd_resp_data <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    rd_resp_v    <= 1'b0;
                    rd_resp_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_reader.sv
// Directed self-checking bench for perf_reader: a 16-bit instance for the main
// scenarios and a 4-bit instance for counter wrap.
module tb_perf_reader;

    logic        clk;
    logic        reset;
    logic        W_v;
    logic        isHalt;
    logic [15:0] cycle;
    logic        rd_req_v;
    logic        rd_req_rdy;
    logic [1:0]  rd_addr;
    logic        rd_resp_v;
    logic        rd_resp_rdy;
    logic [15:0] rd_resp_data;
    logic        halted;

    logic        reset4;
    logic        wv4;
    logic        is_halt4;
    logic [3:0]  cycle4;
    logic        req_v4;
    logic        req_rdy4;
    logic [1:0]  addr4;
    logic        resp_v4;
    logic        resp_rdy4;
    logic [3:0]  data4;
    logic        halted4;

    logic [15:0] m_instret;
    logic [15:0] m_stall;
    logic        m_halted;

    int total;
    int bad;

    perf_reader #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .W_v          (W_v),
        .isHalt       (isHalt),
        .cycle        (cycle),
        .rd_req_v     (rd_req_v),
        .rd_req_rdy   (rd_req_rdy),
        .rd_addr      (rd_addr),
        .rd_resp_v    (rd_resp_v),
        .rd_resp_rdy  (rd_resp_rdy),
        .rd_resp_data (rd_resp_data),
        .halted       (halted)
    );

    perf_reader #(.WIDTH(4)) dut4 (
        .clk          (clk),
        .reset        (reset4),
        .W_v          (wv4),
        .isHalt       (is_halt4),
        .cycle        (cycle4),
        .rd_req_v     (req_v4),
        .rd_req_rdy   (req_rdy4),
        .rd_addr      (addr4),
        .rd_resp_v    (resp_v4),
        .rd_resp_rdy  (resp_rdy4),
        .rd_resp_data (data4),
        .halted       (halted4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; the reference counters follow the inputs seen on it.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_instret = '0;
            m_stall   = '0;
            m_halted  = 1'b0;
        end else if (!m_halted) begin
            if (W_v) m_instret = m_instret + 16'd1;
            else     m_stall   = m_stall + 16'd1;
            if (isHalt) m_halted = 1'b1;
        end
        @(negedge clk);
        cycle = cycle + 16'd1;
    endtask

    task automatic read_reg(input logic [1:0] addr, input logic wv_acc, input logic wv_hs,
                            output logic v, output logic [15:0] d);
        rd_req_v    = 1'b1;
        rd_addr     = addr;
        rd_resp_rdy = 1'b0;
        W_v         = wv_acc;
        tick();
        v           = rd_resp_v;
        d           = rd_resp_data;
        rd_req_v    = 1'b0;
        rd_resp_rdy = 1'b1;
        W_v         = wv_hs;
        tick();
        rd_resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (rd_resp_v !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_v: got %b want 0", rd_resp_v); end
        total++; if (rd_resp_data !== 16'h0) begin bad++; $display("[TB] FAIL reset_resp_data: got %h want 0000", rd_resp_data); end
        total++; if (rd_req_rdy !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_rdy: got %b want 1", rd_req_rdy); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_count();
        logic v;
        logic [15:0] d;
        for (int i = 0; i < 10; i++) begin
            W_v = (i % 2 == 0);
            tick();
        end
        read_reg(2'd1, 1'b1, 1'b1, v, d);
        total++; if (v !== 1'b1) begin bad++; $display("[TB] FAIL count_instret_v: got %b want 1", v); end
        total++; if (d !== 16'd5) begin bad++; $display("[TB] FAIL count_instret: got %0d want 5", d); end
        read_reg(2'd2, 1'b1, 1'b1, v, d);
        total++; if (d !== 16'd5) begin bad++; $display("[TB] FAIL count_stall: got %0d want 5", d); end
        total++; if (rd_resp_data !== 16'h0) begin bad++; $display("[TB] FAIL idle_data_zero: got %h want 0000", rd_resp_data); end
    endtask

    task automatic test_accept_edge();
        logic v;
        logic [15:0] d;
        logic [15:0] first;
        W_v = 1'b0;
        tick();
        first = m_instret;
        read_reg(2'd1, 1'b1, 1'b0, v, d);
        total++; if (d !== first) begin bad++; $display("[TB] FAIL accept_excl: got %0d want %0d", d, first); end
        read_reg(2'd1, 1'b0, 1'b0, v, d);
        total++; if (d !== first + 16'd1) begin bad++; $display("[TB] FAIL accept_next: got %0d want %0d", d, first + 16'd1); end
    endtask

    task automatic test_hold();
        logic v;
        logic [15:0] d;
        logic [15:0] exp;
        exp         = m_instret;
        W_v         = 1'b1;
        rd_req_v    = 1'b1;
        rd_addr     = 2'd1;
        rd_resp_rdy = 1'b0;
        tick();
        rd_addr = 2'd2;
        for (int i = 0; i < 8; i++) begin
            total++; if (rd_resp_v !== 1'b1) begin bad++; $display("[TB] FAIL hold_v[%0d]: got %b want 1", i, rd_resp_v); end
            total++; if (rd_resp_data !== exp) begin bad++; $display("[TB] FAIL hold_data[%0d]: got %0d want %0d", i, rd_resp_data, exp); end
            total++; if (rd_req_rdy !== 1'b0) begin bad++; $display("[TB] FAIL hold_req_rdy[%0d]: got %b want 0", i, rd_req_rdy); end
            tick();
        end
        rd_req_v    = 1'b0;
        rd_resp_rdy = 1'b1;
        tick();
        rd_resp_rdy = 1'b0;
        total++; if (rd_resp_v !== 1'b0) begin bad++; $display("[TB] FAIL hold_release_v: got %b want 0", rd_resp_v); end
        total++; if (rd_req_rdy !== 1'b1) begin bad++; $display("[TB] FAIL hold_release_rdy: got %b want 1", rd_req_rdy); end
        exp = m_instret;
        read_reg(2'd1, 1'b0, 1'b0, v, d);
        total++; if (d !== exp) begin bad++; $display("[TB] FAIL hold_counting: got %0d want %0d", d, exp); end
    endtask

    task automatic test_halt();
        logic v;
        logic [15:0] d;
        logic [15:0] exp_i;
        logic [15:0] exp_s;
        exp_i  = m_instret + 16'd1;
        exp_s  = m_stall;
        W_v    = 1'b1;
        isHalt = 1'b1;
        cycle  = 16'h0040;
        tick();
        isHalt = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_flag: got %b want 1", halted); end
        W_v = 1'b0;
        tick();
        tick();
        W_v = 1'b1;
        tick();
        read_reg(2'd0, 1'b1, 1'b0, v, d);
        total++; if (d !== 16'h0040) begin bad++; $display("[TB] FAIL halt_cycle: got %h want 0040", d); end
        read_reg(2'd3, 1'b0, 1'b1, v, d);
        total++; if (d !== 16'h0001) begin bad++; $display("[TB] FAIL halt_status: got %h want 0001", d); end
        read_reg(2'd1, 1'b1, 1'b1, v, d);
        total++; if (d !== exp_i) begin bad++; $display("[TB] FAIL halt_instret: got %0d want %0d", d, exp_i); end
        read_reg(2'd2, 1'b0, 1'b0, v, d);
        total++; if (d !== exp_s) begin bad++; $display("[TB] FAIL halt_stall: got %0d want %0d", d, exp_s); end
        total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_sticky: got %b want 1", halted); end
    endtask

    task automatic test_width4();
        reset4 = 1'b1;
        tick();
        reset4 = 1'b0;
        wv4    = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        req_v4 = 1'b1;
        addr4  = 2'd1;
        tick();
        total++; if (resp_v4 !== 1'b1) begin bad++; $display("[TB] FAIL w4_resp_v: got %b want 1", resp_v4); end
        total++; if (data4 !== 4'h0) begin bad++; $display("[TB] FAIL w4_instret_wrap: got %h want 0", data4); end
        req_v4    = 1'b0;
        resp_rdy4 = 1'b1;
        tick();
        resp_rdy4 = 1'b0;
        req_v4    = 1'b1;
        addr4     = 2'd3;
        tick();
        total++; if (data4 !== 4'h2) begin bad++; $display("[TB] FAIL w4_status: got %h want 2", data4); end
        req_v4    = 1'b0;
        resp_rdy4 = 1'b1;
        tick();
        resp_rdy4 = 1'b0;
    endtask

    task automatic test_reset_in_resp();
        logic v;
        logic [15:0] d;
        logic [15:0] c;
        rd_req_v    = 1'b1;
        rd_addr     = 2'd1;
        rd_resp_rdy = 1'b0;
        tick();
        total++; if (rd_resp_v !== 1'b1) begin bad++; $display("[TB] FAIL rir_pending: got %b want 1", rd_resp_v); end
        reset  = 1'b1;
        isHalt = 1'b1;
        W_v    = 1'b1;
        tick();
        reset    = 1'b0;
        isHalt   = 1'b0;
        rd_req_v = 1'b0;
        total++; if (rd_resp_v !== 1'b0) begin bad++; $display("[TB] FAIL rir_resp_v: got %b want 0", rd_resp_v); end
        total++; if (rd_resp_data !== 16'h0) begin bad++; $display("[TB] FAIL rir_data: got %h want 0000", rd_resp_data); end
        total++; if (rd_req_rdy !== 1'b1) begin bad++; $display("[TB] FAIL rir_req_rdy: got %b want 1", rd_req_rdy); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL rir_halted: got %b want 0", halted); end
        read_reg(2'd1, 1'b1, 1'b1, v, d);
        total++; if (d !== 16'h0) begin bad++; $display("[TB] FAIL rir_instret: got %0d want 0", d); end
        read_reg(2'd2, 1'b1, 1'b1, v, d);
        total++; if (d !== 16'h0) begin bad++; $display("[TB] FAIL rir_stall: got %0d want 0", d); end
        read_reg(2'd3, 1'b1, 1'b1, v, d);
        total++; if (d !== 16'h0) begin bad++; $display("[TB] FAIL rir_status: got %h want 0000", d); end
        c = cycle;
        read_reg(2'd0, 1'b1, 1'b1, v, d);
        total++; if (d !== c) begin bad++; $display("[TB] FAIL rir_live_cycle: got %h want %h", d, c); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        m_instret   = '0;
        m_stall     = '0;
        m_halted    = 1'b0;
        reset       = 1'b1;
        W_v         = 1'b0;
        isHalt      = 1'b0;
        cycle       = 16'h0;
        rd_req_v    = 1'b0;
        rd_addr     = 2'd0;
        rd_resp_rdy = 1'b0;
        reset4      = 1'b1;
        wv4         = 1'b0;
        is_halt4    = 1'b0;
        cycle4      = 4'h0;
        req_v4      = 1'b0;
        addr4       = 2'd0;
        resp_rdy4   = 1'b0;

        test_reset();
        test_count();
        test_accept_edge();
        test_hold();
        test_halt();
        test_width4();
        test_reset_in_resp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
